rx_cmd_parser: RTL and testbench



---
 rtl/rx_cmd_parser.sv | 212 +++++++++++++++++++++
 tb/tb_rx_cmd_parser.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_cmd_parser.sv
// -----------------------------------------------------------------------------
// rx_cmd_parser
//   Byte-level command parser placed after the UART receiver. Turns multi-byte
//   command frames into register-file write/read strobes and ALU launch strobes.
//
//   Frames (first byte is the opcode):
//     OP_WR      : opcode, addr, data   -> reg_wr_en
//     OP_RD      : opcode, addr         -> reg_rd_en
//     OP_ALU_OPS : opcode, A, B, fun    -> reg_wr_en(0,A), reg_wr_en(1,B), alu_en
//     OP_ALU_NOP : opcode, fun          -> alu_en
//
//   Ports:
//     clk, rst_n    : clock, synchronous active-low reset
//     rx_valid      : one-cycle strobe, rx_data holds a received byte
//     rx_data       : received byte
//     rx_err        : one-cycle receiver error strobe (dominates rx_valid)
//     reg_wr_en     : one-cycle register write strobe
//     reg_rd_en     : one-cycle register read strobe
//     reg_addr      : register address (held between strobes)
//     reg_wr_data   : register write data (held between strobes)
//     alu_en        : one-cycle ALU launch strobe
//     alu_fun       : ALU function code (held between strobes)
//     busy          : a frame is in progress
//     cmd_err       : one-cycle strobe, frame rejected or aborted
// -----------------------------------------------------------------------------
module rx_cmd_parser #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter logic [7:0]  OP_WR       = 8'hAA,
  parameter logic [7:0]  OP_RD       = 8'hBB,
  parameter logic [7:0]  OP_ALU_OPS  = 8'hCC,
  parameter logic [7:0]  OP_ALU_NOP  = 8'hDD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_err,
  output logic              reg_wr_en,
  output logic              reg_rd_en,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wr_data,
  output logic              alu_en,
  output logic [3:0]        alu_fun,
  output logic              busy,
  output logic              cmd_err
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_RD_ADDR,
    S_ALU_A,
    S_ALU_B,
    S_ALU_FUN
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       tmo_cnt_q, tmo_cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

  logic              reg_wr_en_q, reg_wr_en_d;
  logic              reg_rd_en_q, reg_rd_en_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [7:0]        reg_wr_data_q, reg_wr_data_d;
  logic              alu_en_q, alu_en_d;
  logic [3:0]        alu_fun_q, alu_fun_d;
  logic              cmd_err_q, cmd_err_d;

  logic accept;
  logic known_op;
  logic addr_bad;
  logic timeout;
  logic abort;

  assign accept   = rx_valid && !rx_err;
  assign known_op = (rx_data == OP_WR) || (rx_data == OP_RD) ||
                    (rx_data == OP_ALU_OPS) || (rx_data == OP_ALU_NOP);
  // Shifting out the address field leaves the must-be-zero upper bits;
  // for ADDR_W=8 the shift yields zero, so no check applies.
  assign addr_bad = (rx_data >> ADDR_W) != 8'd0;
  // A byte arriving on the last allowed cycle wins over the timeout.
  assign timeout  = (state_q != S_IDLE) && !rx_valid && (tmo_cnt_q == TMO_LAST);
  assign abort    = (state_q != S_IDLE) && (rx_err || timeout);

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      tmo_cnt_q     <= '0;
      wr_addr_q     <= '0;
      reg_wr_en_q   <= 1'b0;
      reg_rd_en_q   <= 1'b0;
      reg_addr_q    <= '0;
      reg_wr_data_q <= '0;
      alu_en_q      <= 1'b0;
      alu_fun_q     <= '0;
      cmd_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmo_cnt_q     <= tmo_cnt_d;
      wr_addr_q     <= wr_addr_d;
      reg_wr_en_q   <= reg_wr_en_d;
      reg_rd_en_q   <= reg_rd_en_d;
      reg_addr_q    <= reg_addr_d;
      reg_wr_data_q <= reg_wr_data_d;
      alu_en_q      <= alu_en_d;
      alu_fun_q     <= alu_fun_d;
      cmd_err_q     <= cmd_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else if (accept) begin
      case (state_q)
        S_IDLE: begin
          if (rx_data == OP_WR)           state_d = S_WR_ADDR;
          else if (rx_data == OP_RD)      state_d = S_RD_ADDR;
          else if (rx_data == OP_ALU_OPS) state_d = S_ALU_A;
          else if (rx_data == OP_ALU_NOP) state_d = S_ALU_FUN;
          else                            state_d = S_IDLE;
        end
        S_WR_ADDR: state_d = addr_bad ? S_IDLE : S_WR_DATA;
        S_WR_DATA: state_d = S_IDLE;
        S_RD_ADDR: state_d = S_IDLE;
        S_ALU_A:   state_d = S_ALU_B;
        S_ALU_B:   state_d = S_ALU_FUN;
        S_ALU_FUN: state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end

    // Inter-byte timer: zero in IDLE and on every accepted byte (which also
    // covers entry into any frame state), otherwise counts silent cycles.
    tmo_cnt_d = tmo_cnt_q;
    if (state_d == S_IDLE || accept) begin
      tmo_cnt_d = '0;
    end else if (!rx_valid) begin
      tmo_cnt_d = tmo_cnt_q + 16'd1;
    end
  end

  // Output logic (next values of the registered outputs)
  always_comb begin
    reg_wr_en_d   = 1'b0;
    reg_rd_en_d   = 1'b0;
    alu_en_d      = 1'b0;
    cmd_err_d     = 1'b0;
    reg_addr_d    = reg_addr_q;
    reg_wr_data_d = reg_wr_data_q;
    alu_fun_d     = alu_fun_q;
    wr_addr_d     = wr_addr_q;

    if (state_q == S_IDLE) begin
      if (accept && !known_op) cmd_err_d = 1'b1;
    end else if (abort) begin
      cmd_err_d = 1'b1;
    end else if (accept) begin
      case (state_q)
        S_WR_ADDR: begin
          if (addr_bad) cmd_err_d = 1'b1;
          else          wr_addr_d = rx_data[ADDR_W-1:0];
        end
        S_WR_DATA: begin
          reg_wr_en_d   = 1'b1;
          reg_addr_d    = wr_addr_q;
          reg_wr_data_d = rx_data;
        end
        S_RD_ADDR: begin
          if (addr_bad) begin
            cmd_err_d = 1'b1;
          end else begin
            reg_rd_en_d = 1'b1;
            reg_addr_d  = rx_data[ADDR_W-1:0];
          end
        end
        S_ALU_A: begin
          reg_wr_en_d   = 1'b1;
          reg_addr_d    = ADDR_W'(0);
          reg_wr_data_d = rx_data;
        end
        S_ALU_B: begin
          reg_wr_en_d   = 1'b1;
          reg_addr_d    = ADDR_W'(1);
          reg_wr_data_d = rx_data;
        end
        S_ALU_FUN: begin
          alu_en_d  = 1'b1;
          alu_fun_d = rx_data[3:0];
        end
        default: ;
      endcase
    end
  end

  assign reg_wr_en   = reg_wr_en_q;
  assign reg_rd_en   = reg_rd_en_q;
  assign reg_addr    = reg_addr_q;
  assign reg_wr_data = reg_wr_data_q;
  assign alu_en      = alu_en_q;
  assign alu_fun     = alu_fun_q;
  assign cmd_err     = cmd_err_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_rx_cmd_parser.sv
module tb_rx_cmd_parser;

  localparam logic [7:0] OWR = 8'hAA;
  localparam logic [7:0] ORD = 8'hBB;
  localparam logic [7:0] OAO = 8'hCC;
  localparam logic [7:0] OAN = 8'hDD;
  localparam int         TMO = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_err = 1'b0;

  // Instance with the default (long) timeout
  logic       wr_en, rd_en, alu_en, busy, cmd_err;
  logic [3:0] addr, fun;
  logic [7:0] wdata;
  // Instance with an 8-cycle timeout
  logic       wr_en8, rd_en8, alu_en8, busy8, cmd_err8;
  logic [3:0] addr8, fun8;
  logic [7:0] wdata8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rx_cmd_parser #(.ADDR_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err),
    .reg_wr_en(wr_en), .reg_rd_en(rd_en), .reg_addr(addr), .reg_wr_data(wdata),
    .alu_en(alu_en), .alu_fun(fun), .busy(busy), .cmd_err(cmd_err)
  );

  rx_cmd_parser #(.ADDR_W(4), .TIMEOUT_CYC(TMO)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err),
    .reg_wr_en(wr_en8), .reg_rd_en(rd_en8), .reg_addr(addr8), .reg_wr_data(wdata8),
    .alu_en(alu_en8), .alu_fun(fun8), .busy(busy8), .cmd_err(cmd_err8)
  );

  // ---------------- behavioural reference model ----------------
  // Keeps the bytes of the frame in progress; the opcode and the number of
  // bytes collected so far decide what each new byte means.
  logic [7:0] m_frame[$];
  int         m_gap;
  logic       e_wr, e_rd, e_alu, e_err, e_busy;
  logic [3:0] e_addr, e_fun;
  logic [7:0] e_wdata;

  task automatic model_reset();
    m_frame.delete();
    m_gap = 0;
    e_wr = 0; e_rd = 0; e_alu = 0; e_err = 0; e_busy = 0;
    e_addr = '0; e_fun = '0; e_wdata = '0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic e);
    logic [7:0] op, a;
    int pos;
    e_wr = 0; e_rd = 0; e_alu = 0; e_err = 0;
    if (m_frame.size() == 0) begin
      if (v && !e) begin
        if (d == OWR || d == ORD || d == OAO || d == OAN) begin
          m_frame.push_back(d);
          m_gap = 0;
        end else begin
          e_err = 1;
        end
      end
    end else if (e) begin
      e_err = 1;
      m_frame.delete();
    end else if (v) begin
      m_gap = 0;
      op  = m_frame[0];
      pos = m_frame.size();
      if ((op == OWR || op == ORD) && pos == 1 && d > 8'd15) begin
        e_err = 1;
        m_frame.delete();
      end else if (op == OWR) begin
        if (pos == 1) m_frame.push_back(d);
        else begin
          a = m_frame[1];
          e_wr = 1; e_addr = a[3:0]; e_wdata = d;
          m_frame.delete();
        end
      end else if (op == ORD) begin
        e_rd = 1; e_addr = d[3:0];
        m_frame.delete();
      end else if (op == OAO) begin
        if (pos < 3) begin
          e_wr = 1; e_addr = 4'(pos - 1); e_wdata = d;
          m_frame.push_back(d);
        end else begin
          e_alu = 1; e_fun = d[3:0];
          m_frame.delete();
        end
      end else begin
        e_alu = 1; e_fun = d[3:0];
        m_frame.delete();
      end
    end else begin
      m_gap++;
      if (m_gap == TMO) begin
        e_err = 1;
        m_frame.delete();
      end
    end
    e_busy = (m_frame.size() != 0);
  endtask

  // ---------------- stimulus helpers ----------------
  // Drive one cycle of input; returns 1 time unit after the sampling edge.
  task automatic send(input logic v, input logic [7:0] d, input logic e);
    rx_valid = v; rx_data = d; rx_err = e;
    @(posedge clk); #1;
    rx_valid = 0; rx_err = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(0, 8'h00, 0);
  endtask

  task automatic do_reset();
    rst_n = 0; rx_valid = 0; rx_err = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 0; rx_valid = 0; rx_err = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({wr_en, rd_en, alu_en, busy, cmd_err} !== 5'b0) begin errors++; $display("FAIL reset_strobes got=%b exp=00000", {wr_en, rd_en, alu_en, busy, cmd_err}); end
    checks++; if ({addr, wdata, fun} !== 16'h0) begin errors++; $display("FAIL reset_data got=%h exp=0000", {addr, wdata, fun}); end
    checks++; if ({wr_en8, rd_en8, alu_en8, busy8, cmd_err8} !== 5'b0) begin errors++; $display("FAIL reset_strobes8 got=%b exp=00000", {wr_en8, rd_en8, alu_en8, busy8, cmd_err8}); end
    rst_n = 1;
  endtask

  task automatic test_reg_write();
    send(1, OWR, 0);
    checks++; if (busy !== 1'b1 || wr_en !== 1'b0) begin errors++; $display("FAIL wr_after_op busy=%b wr_en=%b exp 1/0", busy, wr_en); end
    idle(16);
    send(1, 8'h05, 0);
    idle(16);
    checks++; if (busy !== 1'b1 || wr_en !== 1'b0 || cmd_err !== 1'b0) begin errors++; $display("FAIL wr_wait busy=%b wr_en=%b err=%b exp 1/0/0", busy, wr_en, cmd_err); end
    send(1, 8'h3C, 0);
    checks++; if (wr_en !== 1'b1 || addr !== 4'h5 || wdata !== 8'h3C) begin errors++; $display("FAIL wr_strobe got en=%b addr=%h data=%h exp 1/5/3c", wr_en, addr, wdata); end
    checks++; if (busy !== 1'b0 || cmd_err !== 1'b0 || rd_en !== 1'b0 || alu_en !== 1'b0) begin errors++; $display("FAIL wr_side busy=%b err=%b rd=%b alu=%b exp 0000", busy, cmd_err, rd_en, alu_en); end
    idle(1);
    checks++; if (wr_en !== 1'b0 || addr !== 4'h5 || wdata !== 8'h3C) begin errors++; $display("FAIL wr_hold got en=%b addr=%h data=%h exp 0/5/3c", wr_en, addr, wdata); end
  endtask

  task automatic test_alu_ops();
    send(1, OAO, 0);
    send(1, 8'h12, 0);
    checks++; if (wr_en !== 1'b1 || addr !== 4'h0 || wdata !== 8'h12 || cmd_err !== 1'b0) begin errors++; $display("FAIL alu_opA got en=%b addr=%h data=%h err=%b exp 1/0/12/0", wr_en, addr, wdata, cmd_err); end
    send(1, 8'h34, 0);
    checks++; if (wr_en !== 1'b1 || addr !== 4'h1 || wdata !== 8'h34 || cmd_err !== 1'b0) begin errors++; $display("FAIL alu_opB got en=%b addr=%h data=%h err=%b exp 1/1/34/0", wr_en, addr, wdata, cmd_err); end
    send(1, 8'h07, 0);
    checks++; if (alu_en !== 1'b1 || fun !== 4'h7 || wr_en !== 1'b0 || cmd_err !== 1'b0) begin errors++; $display("FAIL alu_launch got alu=%b fun=%h wr=%b err=%b exp 1/7/0/0", alu_en, fun, wr_en, cmd_err); end
    idle(1);
    checks++; if (alu_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL alu_after got alu=%b busy=%b exp 0/0", alu_en, busy); end
  endtask

  task automatic test_read_bad_addr();
    send(1, ORD, 0);
    send(1, 8'h0A, 0);
    checks++; if (rd_en !== 1'b1 || addr !== 4'hA || cmd_err !== 1'b0) begin errors++; $display("FAIL rd_strobe got rd=%b addr=%h err=%b exp 1/a/0", rd_en, addr, cmd_err); end
    send(1, ORD, 0);
    send(1, 8'h1A, 0);
    checks++; if (cmd_err !== 1'b1 || rd_en !== 1'b0) begin errors++; $display("FAIL rd_badaddr got err=%b rd=%b exp 1/0", cmd_err, rd_en); end
    idle(1);
    checks++; if (busy !== 1'b0 || cmd_err !== 1'b0) begin errors++; $display("FAIL rd_after got busy=%b err=%b exp 0/0", busy, cmd_err); end
  endtask

  task automatic test_unknown_op();
    send(1, 8'h55, 0);
    checks++; if (cmd_err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL unk_op got err=%b busy=%b exp 1/0", cmd_err, busy); end
    send(1, OAN, 0);
    checks++; if (cmd_err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL nop_op got err=%b busy=%b exp 0/1", cmd_err, busy); end
    send(1, 8'hF3, 0);
    checks++; if (alu_en !== 1'b1 || fun !== 4'h3) begin errors++; $display("FAIL nop_launch got alu=%b fun=%h exp 1/3", alu_en, fun); end
  endtask

  task automatic test_timeout();
    int seen_at;
    int early;
    do_reset();
    send(1, OWR, 0);
    seen_at = -1;
    for (int i = 1; i <= 20 && seen_at < 0; i++) begin
      send(0, 8'h00, 0);
      if (cmd_err8 === 1'b1) seen_at = i;
    end
    checks++; if (seen_at != TMO) begin errors++; $display("FAIL tmo_fire got cycle=%0d exp=%0d", seen_at, TMO); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL tmo_idle got busy=%b exp 0", busy8); end
    send(1, OWR, 0);
    early = 0;
    for (int i = 0; i < TMO - 1; i++) begin
      send(0, 8'h00, 0);
      if (cmd_err8 !== 1'b0) early++;
    end
    send(1, 8'h05, 0);
    checks++; if (early != 0 || cmd_err8 !== 1'b0 || busy8 !== 1'b1) begin errors++; $display("FAIL tmo_edge got early=%0d err=%b busy=%b exp 0/0/1", early, cmd_err8, busy8); end
    send(1, 8'h3C, 0);
    checks++; if (wr_en8 !== 1'b1 || addr8 !== 4'h5 || wdata8 !== 8'h3C) begin errors++; $display("FAIL tmo_wr got en=%b addr=%h data=%h exp 1/5/3c", wr_en8, addr8, wdata8); end
  endtask

  task automatic test_abort_reset();
    send(1, OWR, 0);
    send(1, 8'h05, 0);
    send(1, 8'h3C, 1);
    checks++; if (cmd_err !== 1'b1 || wr_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_err got err=%b wr=%b busy=%b exp 1/0/0", cmd_err, wr_en, busy); end
    send(1, OAO, 0);
    send(1, 8'h12, 0);
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    checks++; if ({wr_en, rd_en, alu_en, busy, cmd_err} !== 5'b0 || {addr, wdata, fun} !== 16'h0) begin errors++; $display("FAIL midreset got ctl=%b data=%h exp 00000/0000", {wr_en, rd_en, alu_en, busy, cmd_err}, {addr, wdata, fun}); end
    send(1, OAN, 0);
    send(1, 8'h01, 0);
    checks++; if (alu_en !== 1'b1 || fun !== 4'h1 || cmd_err !== 1'b0) begin errors++; $display("FAIL reset_recover got alu=%b fun=%h err=%b exp 1/1/0", alu_en, fun, cmd_err); end
  endtask

  task automatic test_random();
    int vp;
    logic v, e;
    logic [7:0] d;
    int bad;
    do_reset();
    model_reset();
    vp = 50;
    bad = 0;
    for (int c = 0; c < 4000 && bad < 20; c++) begin
      if (c % 64 == 0) begin
        case ($urandom_range(0, 2))
          0: vp = 10;
          1: vp = 50;
          default: vp = 95;
        endcase
      end
      v = ($urandom_range(0, 99) < vp);
      e = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 5))
        0: d = OWR;
        1: d = ORD;
        2: d = OAO;
        3: d = OAN;
        4: d = 8'($urandom_range(0, 15));
        default: d = 8'($urandom);
      endcase
      model_step(v, d, e);
      send(v, d, e);
      checks++; if (wr_en8 !== e_wr) begin errors++; bad++; $display("FAIL rnd_wr_en cyc=%0d got=%b exp=%b", c, wr_en8, e_wr); end
      checks++; if (rd_en8 !== e_rd) begin errors++; bad++; $display("FAIL rnd_rd_en cyc=%0d got=%b exp=%b", c, rd_en8, e_rd); end
      checks++; if (alu_en8 !== e_alu) begin errors++; bad++; $display("FAIL rnd_alu_en cyc=%0d got=%b exp=%b", c, alu_en8, e_alu); end
      checks++; if (cmd_err8 !== e_err) begin errors++; bad++; $display("FAIL rnd_cmd_err cyc=%0d got=%b exp=%b", c, cmd_err8, e_err); end
      checks++; if (busy8 !== e_busy) begin errors++; bad++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", c, busy8, e_busy); end
      checks++; if (addr8 !== e_addr) begin errors++; bad++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", c, addr8, e_addr); end
      checks++; if (wdata8 !== e_wdata) begin errors++; bad++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", c, wdata8, e_wdata); end
      checks++; if (fun8 !== e_fun) begin errors++; bad++; $display("FAIL rnd_fun cyc=%0d got=%h exp=%h", c, fun8, e_fun); end
    end
  endtask

  initial begin
    test_reset();
    test_reg_write();
    test_alu_ops();
    test_read_bad_addr();
    test_unknown_op();
    test_timeout();
    do_reset();
    test_abort_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
